banco_registros_tx: RTL

- Parametrised data register bank with two write ports, one combinational read port and a buffered transmit path toward the UART.
- Every accepted write to the designated TX register is also pushed into a small FIFO.
- The UART drains the FIFO through a valid/ready handshake, so back-to-back updates are no longer lost.
- Sits between the processor/control path and the UART transmitter.

---
 rtl/banco_registros_tx.sv | 96 +++++++++
 1 files changed

// File: rtl/banco_registros_tx.sv
// Register bank with two write ports and one combinational read port. Writes to
// TX_ADDR are also queued in a small FIFO that the UART drains by handshake.
module banco_registros_tx #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 4,
    parameter int IN2_W      = 8,
    parameter int TX_ADDR    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr1_d,
    input  logic [AW-1:0]     addr1,
    input  logic [DATA_W-1:0] in1,
    input  logic              wr2_d,
    input  logic [AW-1:0]     addr2,
    input  logic [DATA_W-1:0] in2,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] out,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [CW-1:0]     fifo_count,
    output logic              ovf,
    input  logic              ovf_clr
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] registros [NUM_REGS];
    logic [DATA_W-1:0] fifo_mem  [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] in2_ext;
    logic              acc1, acc2, hit1, hit2;
    logic              push, pop, full, push_ok;
    logic [DATA_W-1:0] push_data;

    assign in2_ext = DATA_W'(in2[IN2_W-1:0]);
    assign acc1    = wr1_d && (int'(addr1) < NUM_REGS);
    assign acc2    = wr2_d && (int'(addr2) < NUM_REGS);
    assign hit1    = acc1 && (int'(addr1) == TX_ADDR);
    assign hit2    = acc2 && (int'(addr2) == TX_ADDR);

    // Port 2 wins a collision, so it also supplies the pushed value.
    assign push      = hit1 || hit2;
    assign push_data = hit2 ? in2_ext : in1;

    // Handshake: tx_valid means tx_data holds the FIFO head; a pop happens on
    // any rising edge where tx_valid && tx_ready. tx_data stays put until then.
    assign tx_valid = (fifo_count != '0);
    assign tx_data  = fifo_mem[rd_ptr];
    assign full     = (int'(fifo_count) == FIFO_DEPTH);
    assign pop      = tx_valid && tx_ready;
    assign push_ok  = push && (!full || pop);

    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_addr) == i) out = registros[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) registros[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (acc2 && int'(addr2) == i)      registros[i] <= in2_ext;
                else if (acc1 && int'(addr1) == i) registros[i] <= in1;
            end
        end
    end

    // Explicit wrap keeps non-power-of-two depths correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
            if (push && !push_ok)     ovf <= 1'b1;
            else if (ovf_clr)         ovf <= 1'b0;
        end
    end
endmodule
